// File: rtl/usb_hub_pkg.sv
// Shared line-state encoding and repeater FSM state encoding for the hub repeater.
package usb_hub_pkg;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DOWN  = 2'd1,
        RPT_UP    = 2'd2,
        RPT_FLUSH = 2'd3
    } rpt_state_e;

endpackage

// File: rtl/usb_hub_repeater_if.sv
// Line-state bundle between the hub repeater core (master) and the transceivers (slave).
interface usb_hub_repeater_if #(
    parameter int NUM_USB_DEVICES = 2
);
    logic [1:0]                   host_line_state;
    logic [2*NUM_USB_DEVICES-1:0] dev_line_state;
    logic [NUM_USB_DEVICES-1:0]   port_enable;
    logic                         host_drive;
    logic [1:0]                   host_line_out;
    logic [NUM_USB_DEVICES-1:0]   dev_drive;
    logic [1:0]                   dev_line_out;
    logic [NUM_USB_DEVICES-1:0]   active_port;
    logic [NUM_USB_DEVICES-1:0]   babble_port;
    logic [1:0]                   rpt_state;

    modport master (
        input  host_line_state, dev_line_state, port_enable,
        output host_drive, host_line_out, dev_drive, dev_line_out,
               active_port, babble_port, rpt_state
    );

    modport slave (
        output host_line_state, dev_line_state, port_enable,
        input  host_drive, host_line_out, dev_drive, dev_line_out,
               active_port, babble_port, rpt_state
    );
endinterface

// File: rtl/usb_line_eop_det.sv
// Per-line SOP (J->K) and EOP (SE0 run of at least EOP_MIN_CYCLES, then J) detector.
module usb_line_eop_det
    import usb_hub_pkg::*;
#(
    parameter int EOP_MIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] line_state,
    output logic       sop,
    output logic       eop
);
    localparam int RW = $clog2(EOP_MIN_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MIN = RW'(EOP_MIN_CYCLES);

    logic [1:0]    prev;
    logic [RW-1:0] se0_run;

    // SE1 and K both break an SE0 run; the run saturates at the qualifying length.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= LS_J;
            se0_run <= '0;
        end else begin
            prev <= line_state;
            if (line_state != LS_SE0)
                se0_run <= '0;
            else if (se0_run != RUN_MIN)
                se0_run <= se0_run + RW'(1);
        end
    end

    assign sop = (prev == LS_J) && (line_state == LS_K);
    assign eop = (line_state == LS_J) && (se0_run == RUN_MIN);

endmodule

// File: rtl/usb_hub_repeater.sv
// Packet-level hub repeater: host traffic broadcast downstream, one upstream owner per packet.
//   state | meaning
//   IDLE  | no packet; waiting for host or device SOP
//   DOWN  | forwarding host line to enabled, unlocked ports
//   UP    | forwarding the active port's line to the host
//   FLUSH | SE0, SE0, J toward the current direction after babble/disable
module usb_hub_repeater
    import usb_hub_pkg::*;
#(
    parameter int NUM_USB_DEVICES = 2,
    parameter int EOP_MIN_CYCLES  = 2,
    parameter int MAX_PKT_CYCLES  = 1024
) (
    input  logic               hi_clock,
    input  logic               reset,
    usb_hub_repeater_if.master bus
);
    localparam int N  = NUM_USB_DEVICES;
    localparam int CW = $clog2(MAX_PKT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PKT_CYCLES);

    rpt_state_e    state, state_d;
    logic [CW-1:0] pkt_cnt, pkt_cnt_d, pkt_inc;
    logic          flush_cnt, flush_cnt_d;
    logic [N-1:0]  lock, lock_d;
    logic          host_drive_q, host_drive_d;
    logic [1:0]    host_line_q, host_line_d, dev_line_q, dev_line_d, sel_line;
    logic [N-1:0]  dev_drive_q, dev_drive_d, active_q, active_d, babble_q, babble_d;
    logic          host_sop, host_eop, active_en, active_eop;
    logic [N-1:0]  dev_sop, dev_eop, cand, grant, sel_port;

    usb_line_eop_det #(.EOP_MIN_CYCLES(EOP_MIN_CYCLES)) u_host_det (
        .clk(hi_clock), .reset(reset), .line_state(bus.host_line_state),
        .sop(host_sop), .eop(host_eop)
    );

    for (genvar i = 0; i < N; i++) begin : g_dev_det
        usb_line_eop_det #(.EOP_MIN_CYCLES(EOP_MIN_CYCLES)) u_det (
            .clk(hi_clock), .reset(reset), .line_state(bus.dev_line_state[2*i +: 2]),
            .sop(dev_sop[i]), .eop(dev_eop[i])
        );
    end

    // Lowest set bit of the candidate vector wins the upstream path.
    assign cand       = dev_sop & bus.port_enable & ~lock;
    assign grant      = cand & (~cand + N'(1));
    assign sel_port   = (state == RPT_IDLE) ? grant : active_q;
    assign active_en  = |(bus.port_enable & active_q);
    assign active_eop = |(dev_eop & active_q);
    assign pkt_inc    = (pkt_cnt == CNT_MAX) ? pkt_cnt : pkt_cnt + CW'(1);

    always_comb begin
        sel_line = LS_J;
        for (int i = 0; i < N; i++)
            if (sel_port[i]) sel_line = bus.dev_line_state[2*i +: 2];
    end

    always_comb begin
        state_d      = state;
        pkt_cnt_d    = pkt_cnt;
        flush_cnt_d  = flush_cnt;
        lock_d       = lock & bus.port_enable;
        host_drive_d = 1'b0;
        host_line_d  = LS_J;
        dev_drive_d  = '0;
        dev_line_d   = LS_J;
        active_d     = active_q;
        babble_d     = '0;
        unique case (state)
            RPT_IDLE: begin
                if (host_sop) begin
                    state_d     = RPT_DOWN;
                    pkt_cnt_d   = '0;
                    dev_drive_d = bus.port_enable & ~lock;
                    dev_line_d  = bus.host_line_state;
                end else if (|grant) begin
                    state_d      = RPT_UP;
                    pkt_cnt_d    = '0;
                    active_d     = grant;
                    host_drive_d = 1'b1;
                    host_line_d  = sel_line;
                end
            end
            RPT_DOWN: begin
                pkt_cnt_d   = pkt_inc;
                dev_drive_d = bus.port_enable & ~lock;
                dev_line_d  = bus.host_line_state;
                if (host_eop) begin
                    state_d = RPT_IDLE;
                end else if (pkt_cnt == CNT_LAST) begin
                    state_d     = RPT_FLUSH;
                    flush_cnt_d = 1'b0;
                    dev_line_d  = LS_SE0;
                end
            end
            RPT_UP: begin
                pkt_cnt_d    = pkt_inc;
                host_drive_d = 1'b1;
                host_line_d  = sel_line;
                if (!active_en) begin
                    state_d     = RPT_FLUSH;
                    flush_cnt_d = 1'b0;
                    host_line_d = LS_SE0;
                end else if (active_eop) begin
                    state_d  = RPT_IDLE;
                    active_d = '0;
                end else if (pkt_cnt == CNT_LAST) begin
                    state_d     = RPT_FLUSH;
                    flush_cnt_d = 1'b0;
                    host_line_d = LS_SE0;
                    babble_d    = active_q;
                    lock_d      = lock_d | active_q;
                end
            end
            RPT_FLUSH: begin
                // A retained owner means the flush goes upstream.
                if (|active_q) begin
                    host_drive_d = 1'b1;
                    host_line_d  = flush_cnt ? LS_J : LS_SE0;
                end else begin
                    dev_drive_d = bus.port_enable & ~lock;
                    dev_line_d  = flush_cnt ? LS_J : LS_SE0;
                end
                if (flush_cnt) begin
                    state_d     = RPT_IDLE;
                    active_d    = '0;
                    flush_cnt_d = 1'b0;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge hi_clock) begin
        if (reset) begin
            state        <= RPT_IDLE;
            pkt_cnt      <= '0;
            flush_cnt    <= 1'b0;
            lock         <= '0;
            host_drive_q <= 1'b0;
            host_line_q  <= LS_J;
            dev_drive_q  <= '0;
            dev_line_q   <= LS_J;
            active_q     <= '0;
            babble_q     <= '0;
        end else begin
            state        <= state_d;
            pkt_cnt      <= pkt_cnt_d;
            flush_cnt    <= flush_cnt_d;
            lock         <= lock_d;
            host_drive_q <= host_drive_d;
            host_line_q  <= host_line_d;
            dev_drive_q  <= dev_drive_d;
            dev_line_q   <= dev_line_d;
            active_q     <= active_d;
            babble_q     <= babble_d;
        end
    end

    assign bus.host_drive    = host_drive_q;
    assign bus.host_line_out = host_line_q;
    assign bus.dev_drive     = dev_drive_q;
    assign bus.dev_line_out  = dev_line_q;
    assign bus.active_port   = active_q;
    assign bus.babble_port   = babble_q;
    assign bus.rpt_state     = state;

endmodule

// File: tb/tb_usb_hub_repeater.sv
// Directed and randomized packet-level checks of usb_hub_repeater with two ports.
module tb_usb_hub_repeater;
    import usb_hub_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    usb_hub_repeater_if #(.NUM_USB_DEVICES(2)) bus ();

    usb_hub_repeater #(
        .NUM_USB_DEVICES(2), .EOP_MIN_CYCLES(2), .MAX_PKT_CYCLES(16)
    ) dut (
        .hi_clock(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic hd, input logic [1:0] hl,
                           input logic [1:0] dd, input logic [1:0] dl, input logic [1:0] ap,
                           input logic [1:0] bp, input logic [1:0] st);
        chk({tag, "/host_drive"},    32'(bus.host_drive),    32'(hd));
        chk({tag, "/host_line_out"}, 32'(bus.host_line_out), 32'(hl));
        chk({tag, "/dev_drive"},     32'(bus.dev_drive),     32'(dd));
        chk({tag, "/dev_line_out"},  32'(bus.dev_line_out),  32'(dl));
        chk({tag, "/active_port"},   32'(bus.active_port),   32'(ap));
        chk({tag, "/babble_port"},   32'(bus.babble_port),   32'(bp));
        chk({tag, "/rpt_state"},     32'(bus.rpt_state),     32'(st));
    endtask

    // Apply host, dev1, dev0 line states, clock once, then settle before sampling.
    task automatic drive(input logic [1:0] h, input logic [1:0] d1, input logic [1:0] d0);
        bus.host_line_state = h;
        bus.dev_line_state  = {d1, d0};
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] J = LS_J, K = LS_K, S0 = LS_SE0;

    int         kind, plen, port, win_port;
    logic       use_h;
    logic [1:0] use_d, sym, lose_sym, h, dv0, dv1;
    logic [1:0] ws [0:15];
    logic       e_hd;
    logic [1:0] e_hl, e_dd, e_dl, e_ap, e_st;

    initial begin
        reset = 1'b1;
        bus.port_enable = 2'b11;
        drive(J, J, J);
        drive(J, J, J);
        reset = 1'b0;
        chk_all("reset", 0, J, 0, J, 0, 0, RPT_IDLE);

        // Host packet: J, K x8, SE0 x2, J
        drive(J, J, J);
        drive(K, J, J);  chk_all("hp_sop", 0, J, 2'b11, K, 0, 0, RPT_DOWN);
        for (int i = 0; i < 7; i++) begin
            drive(K, J, J); chk_all("hp_k", 0, J, 2'b11, K, 0, 0, RPT_DOWN);
        end
        drive(S0, J, J); chk_all("hp_se0a", 0, J, 2'b11, S0, 0, 0, RPT_DOWN);
        drive(S0, J, J); chk_all("hp_se0b", 0, J, 2'b11, S0, 0, 0, RPT_DOWN);
        drive(J, J, J);  chk_all("hp_eop", 0, J, 2'b11, J, 0, 0, RPT_IDLE);
        drive(J, J, J);  chk_all("hp_end", 0, J, 0, J, 0, 0, RPT_IDLE);

        // Host and dev1 SOP together: host wins
        drive(K, K, J);  chk_all("sim_sop", 0, J, 2'b11, K, 0, 0, RPT_DOWN);
        drive(S0, J, J); drive(S0, J, J);
        drive(J, J, J);  chk_all("sim_eop", 0, J, 2'b11, J, 0, 0, RPT_IDLE);
        drive(J, J, J);  chk_all("sim_end", 0, J, 0, J, 0, 0, RPT_IDLE);

        // dev0 and dev1 SOP together: dev0 wins, only its line goes upstream
        drive(J, K, K);    chk_all("two_sop", 1, K, 0, J, 2'b01, 0, RPT_UP);
        drive(J, LS_SE1, J); chk_all("two_j", 1, J, 0, J, 2'b01, 0, RPT_UP);
        drive(J, S0, K);   chk_all("two_k", 1, K, 0, J, 2'b01, 0, RPT_UP);
        drive(J, J, S0);   drive(J, J, S0);
        drive(J, J, J);    chk_all("two_eop", 1, J, 0, J, 0, 0, RPT_IDLE);
        drive(J, J, J);    chk_all("two_end", 0, J, 0, J, 0, 0, RPT_IDLE);

        // Single SE0 mid-packet is forwarded and is not an EOP
        drive(J, J, K);  chk_all("short_sop", 1, K, 0, J, 2'b01, 0, RPT_UP);
        drive(J, J, S0); chk_all("short_se0", 1, S0, 0, J, 2'b01, 0, RPT_UP);
        drive(J, J, J);  chk_all("short_j", 1, J, 0, J, 2'b01, 0, RPT_UP);
        drive(J, J, K);  chk_all("short_k", 1, K, 0, J, 2'b01, 0, RPT_UP);
        drive(J, J, S0); drive(J, J, S0);
        drive(J, J, J);  chk_all("short_eop", 1, J, 0, J, 0, 0, RPT_IDLE);
        drive(J, J, J);  chk_all("short_end", 0, J, 0, J, 0, 0, RPT_IDLE);

        // Active port disabled mid-packet flushes upstream
        drive(J, J, K);  chk_all("dis_sop", 1, K, 0, J, 2'b01, 0, RPT_UP);
        bus.port_enable = 2'b10;
        drive(J, J, K);  chk_all("dis_f0", 1, S0, 0, J, 2'b01, 0, RPT_FLUSH);
        drive(J, J, J);  chk_all("dis_f1", 1, S0, 0, J, 2'b01, 0, RPT_FLUSH);
        drive(J, J, J);  chk_all("dis_fj", 1, J, 0, J, 0, 0, RPT_IDLE);
        drive(J, J, J);  chk_all("dis_end", 0, J, 0, J, 0, 0, RPT_IDLE);
        bus.port_enable = 2'b11;

        // Babble: dev1 toggles K/J for 20 cycles, limit is 16
        for (int c = 0; c < 20; c++) begin
            sym = (c % 2 == 0) ? K : J;
            drive(J, sym, J);
            if (c <= 15)      chk_all("bab_up", 1, sym, 0, J, 2'b10, 0, RPT_UP);
            else if (c == 16) chk_all("bab_pulse", 1, S0, 0, J, 2'b10, 2'b10, RPT_FLUSH);
            else if (c == 17) chk_all("bab_f1", 1, S0, 0, J, 2'b10, 0, RPT_FLUSH);
            else if (c == 18) chk_all("bab_fj", 1, J, 0, J, 0, 0, RPT_IDLE);
            else              chk_all("bab_end", 0, J, 0, J, 0, 0, RPT_IDLE);
        end
        drive(J, K, J);  chk_all("lock_ign", 0, J, 0, J, 0, 0, RPT_IDLE);
        drive(J, J, J);
        drive(K, J, J);  chk_all("lock_down", 0, J, 2'b01, K, 0, 0, RPT_DOWN);
        drive(S0, J, J); drive(S0, J, J);
        drive(J, J, J);  chk_all("lock_eop", 0, J, 2'b01, J, 0, 0, RPT_IDLE);
        drive(J, J, J);
        bus.port_enable = 2'b01;
        drive(J, J, J);
        bus.port_enable = 2'b11;
        drive(J, J, J);
        drive(J, K, J);  chk_all("unlock_sop", 1, K, 0, J, 2'b10, 0, RPT_UP);
        drive(J, S0, J); drive(J, S0, J);
        drive(J, J, J);  chk_all("unlock_eop", 1, J, 0, J, 0, 0, RPT_IDLE);
        drive(J, J, J);

        // Reset mid-packet aborts without a flush
        drive(J, J, K);  chk_all("rst_sop", 1, K, 0, J, 2'b01, 0, RPT_UP);
        drive(J, J, K);
        reset = 1'b1;
        drive(J, J, K);  chk_all("rst_up", 0, J, 0, J, 0, 0, RPT_IDLE);
        reset = 1'b0;
        drive(J, J, J);  chk_all("rst_after", 0, J, 0, J, 0, 0, RPT_IDLE);

        // Randomized packets checked against packet-window expectations
        for (int p = 0; p < 40; p++) begin
            kind  = $urandom_range(0, 3);
            plen  = $urandom_range(1, 9);
            port  = $urandom_range(0, 1);
            use_h = (kind == 0) || (kind == 3);
            use_d = (kind == 0) ? 2'b00 : (kind == 2) ? 2'b11 : (2'b01 << port);
            win_port = use_d[0] ? 0 : 1;
            for (int k = 0; k < plen + 5; k++) begin
                if (k == 0) sym = K;
                else if (k < plen) begin
                    sym = 2'($urandom_range(0, 3));
                    if (sym == S0 && (ws[k-1] == S0 || k == plen - 1)) sym = K;
                end else if (k < plen + 2) sym = S0;
                else sym = J;
                ws[k] = sym;
            end
            for (int k = 0; k < plen + 5; k++) begin
                lose_sym = (k == 0) ? K : (k < plen + 2) ? 2'($urandom_range(0, 3)) : J;
                h   = use_h ? ws[k] : J;
                dv0 = !use_d[0] ? J : (!use_h && win_port == 0) ? ws[k] : lose_sym;
                dv1 = !use_d[1] ? J : (!use_h && win_port == 1) ? ws[k] : lose_sym;
                drive(h, dv1, dv0);
                e_hd = 0; e_hl = J; e_dd = 0; e_dl = J; e_ap = 0; e_st = RPT_IDLE;
                if (k <= plen + 2) begin
                    if (use_h) begin e_dd = 2'b11; e_dl = ws[k]; end
                    else       begin e_hd = 1;     e_hl = ws[k]; end
                    if (k < plen + 2) begin
                        e_st = use_h ? RPT_DOWN : RPT_UP;
                        if (!use_h) e_ap = 2'b01 << win_port;
                    end
                end
                chk_all("rand", e_hd, e_hl, e_dd, e_dl, e_ap, 0, e_st);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
